// File: rtl/noc_recv_pkg.sv
// noc_recv_pkg: flit field positions and receive FSM states shared by the
// NoC receive-address queue.
`default_nettype none

package noc_recv_pkg;

  localparam int SRC_LSB = 0;
  localparam int LEN_LSB = 8;
  localparam int LEN_W   = 8;
  // Header flag position for the default 32-bit flit; wider/narrower flits use hdr_bit().
  localparam int HDR_BIT = 31;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_e;

  function automatic int hdr_bit(input int flit_w);
    return flit_w - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/recv_addr_fifo.sv
// recv_addr_fifo: circular address buffer whose head output is a register that
// holds the last delivered address once the queue drains.
`default_nettype none

module recv_addr_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = head_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The new head may be the slot being written this very cycle.
    if (count_d != '0) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = wdata_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_recv_addr_queue.sv
// noc_recv_addr_queue: parses NoC flits, queues packet source addresses for the
// Nios PIO and skips payload. Optional framing checks: RECV_ADDR_FRAMING_CHECK_EN.
`default_nettype none

module noc_recv_addr_queue
  import noc_recv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int FLIT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic [ADDR_W-1:0] recv_addr,
  output logic              recv_pending,
  input  logic              recv_ack,
  output logic              overflow,
  output logic              framing_err,
  input  logic              clr_err
);

  localparam int HDR = hdr_bit(FLIT_W);

  rx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              ack_q;
  logic              ovf_q, ovf_d, ovf_set;
  logic              fifo_full, fifo_empty;
  logic              push, pop, xfer, is_hdr;
  logic [LEN_W-1:0]  hdr_len;
  logic [ADDR_W-1:0] hdr_src;

  assign xfer       = flit_valid && flit_ready;
  assign is_hdr     = flit_in[HDR];
  assign hdr_len    = flit_in[LEN_LSB +: LEN_W];
  assign hdr_src    = flit_in[SRC_LSB +: ADDR_W];
  assign flit_ready = !((state_q == IDLE) && fifo_full);
  assign pop        = recv_ack && !ack_q;

  if (FLIT_W > 17) begin : g_unused_flit
    logic unused_flit_bits;
    assign unused_flit_bits = ^flit_in[FLIT_W-2:LEN_LSB+LEN_W];
  end

`ifdef RECV_ADDR_FRAMING_CHECK_EN
  logic ferr_q, ferr_d, ferr_set;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
`ifdef RECV_ADDR_FRAMING_CHECK_EN
    ferr_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (is_hdr) begin
            push  = 1'b1;
            cnt_d = hdr_len;
            if (hdr_len != '0) state_d = PAYLOAD;
          end
`ifdef RECV_ADDR_FRAMING_CHECK_EN
          else ferr_set = 1'b1;
`endif
        end
      end
      PAYLOAD: begin
        if (xfer) begin
`ifdef RECV_ADDR_FRAMING_CHECK_EN
          // A header here restarts framing; it may be dropped if the queue is full.
          if (is_hdr) begin
            ferr_set = 1'b1;
            cnt_d    = hdr_len;
            if (fifo_full) ovf_set = 1'b1;
            else           push    = 1'b1;
            if (hdr_len == '0) state_d = IDLE;
          end else
`endif
          begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over a same-cycle clear.
  assign ovf_d = ovf_set | (ovf_q & ~clr_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= recv_ack;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RECV_ADDR_FRAMING_CHECK_EN
  assign ferr_d = ferr_set | (ferr_q & ~clr_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ferr_q <= 1'b0;
    else          ferr_q <= ferr_d;
  end

  assign framing_err = ferr_q;
`else
  assign framing_err = 1'b0;
`endif

  assign overflow = ovf_q;

  recv_addr_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (hdr_src),
    .pop_i   (pop),
    .head_o  (recv_addr),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign recv_pending = !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_noc_recv_addr_queue.sv
// tb_noc_recv_addr_queue: directed and random stimulus checked against a
// queue-based behavioural model of the receive-address queue.
`default_nettype none

module tb_noc_recv_addr_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int FLIT_W = 32;
`ifdef RECV_ADDR_FRAMING_CHECK_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [FLIT_W-1:0] flit_in = '0;
  logic              flit_valid = 1'b0;
  logic              flit_ready;
  logic [ADDR_W-1:0] recv_addr;
  logic              recv_pending;
  logic              recv_ack = 1'b0;
  logic              overflow;
  logic              framing_err;
  logic              clr_err = 1'b0;

  noc_recv_addr_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FLIT_W(FLIT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flit_in      (flit_in),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .recv_addr    (recv_addr),
    .recv_pending (recv_pending),
    .recv_ack     (recv_ack),
    .overflow     (overflow),
    .framing_err  (framing_err),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int checks = 0;

  // Behavioural model: queue of addresses, payload flits still expected.
  logic [7:0] mq[$];
  int         m_rem = 0;
  bit         m_ack_prev = 1'b0;
  logic [7:0] m_addr = '0;
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    m_rem = 0; m_ack_prev = 1'b0; m_addr = '0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_update();
    bit         acc, hdr, push_it, pop_it, fset, oset, full_b;
    logic [7:0] len, src;
    full_b  = (mq.size() == DEPTH);
    acc     = flit_valid && !(m_rem == 0 && full_b);
    hdr     = flit_in[FLIT_W-1];
    len     = flit_in[15:8];
    src     = flit_in[7:0];
    push_it = 1'b0; fset = 1'b0; oset = 1'b0;
    pop_it  = recv_ack && !m_ack_prev && (mq.size() != 0);
    if (acc) begin
      if (m_rem == 0) begin
        if (hdr) begin push_it = 1'b1; m_rem = int'(len); end
        else if (FRAMING) fset = 1'b1;
      end else if (FRAMING && hdr) begin
        fset = 1'b1; m_rem = int'(len);
        if (full_b) oset = 1'b1; else push_it = 1'b1;
      end else begin
        m_rem--;
      end
    end
    if (pop_it) void'(mq.pop_front());
    if (push_it) mq.push_back(src);
    m_ack_prev = recv_ack;
    m_ovf  = oset | (m_ovf & !clr_err);
    m_ferr = fset | (m_ferr & !clr_err);
    if (mq.size() != 0) m_addr = mq[0];
  endtask

  task automatic check_outputs();
    chk("recv_addr",    32'(recv_addr),    32'(m_addr));
    chk("recv_pending", 32'(recv_pending), 32'(mq.size() != 0));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("framing_err",  32'(framing_err),  32'(m_ferr));
  endtask

  // One clock: check ready before the edge, advance the model, check after.
  task automatic step();
    chk("flit_ready", 32'(flit_ready), 32'(!(m_rem == 0 && mq.size() == DEPTH)));
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] mk_flit(input bit hdr, input logic [7:0] len, input logic [7:0] src);
    return {hdr, 15'h1234, len, src};
  endfunction

  task automatic send(input bit hdr, input logic [7:0] len, input logic [7:0] src);
    flit_valid = 1'b1;
    flit_in    = mk_flit(hdr, len, src);
    step();
    flit_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    recv_ack = 1'b1;
    step();
    recv_ack = 1'b0;
    step();
  endtask

  task automatic do_reset();
    flit_valid = 1'b0; recv_ack = 1'b0; clr_err = 1'b0;
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("rst_recv_addr",    32'(recv_addr),    32'h0);
    chk("rst_recv_pending", 32'(recv_pending), 32'h0);
    chk("rst_overflow",     32'(overflow),     32'h0);
    chk("rst_framing_err",  32'(framing_err),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_flit_ready", 32'(flit_ready), 32'h1);

    // Single header, zero payload, then ack.
    send(1'b1, 8'd0, 8'h2A);
    chk("t1_addr", 32'(recv_addr), 32'h2A);
    chk("t1_pend", 32'(recv_pending), 32'h1);
    recv_ack = 1'b1;
    step();
    chk("t1_pop_pend", 32'(recv_pending), 32'h0);
    chk("t1_hold_addr", 32'(recv_addr), 32'h2A);
    recv_ack = 1'b0;
    step();

    // Payload is skipped, not queued.
    send(1'b1, 8'd3, 8'h05);
    for (int i = 0; i < 3; i++) send(1'b0, 8'h00, 8'hE0 + 8'(i));
    send(1'b1, 8'd0, 8'h06);
    chk("t2_head", 32'(recv_addr), 32'h05);
    ack_pulse();
    chk("t2_second", 32'(recv_addr), 32'h06);
    ack_pulse();
    chk("t2_empty", 32'(recv_pending), 32'h0);

    // Backpressure on a full queue, then drain in order.
    for (int i = 0; i < 4; i++) send(1'b1, 8'd0, 8'h10 + 8'(i));
    flit_valid = 1'b1;
    flit_in    = mk_flit(1'b1, 8'd0, 8'h14);
    chk("t3_full_ready", 32'(flit_ready), 32'h0);
    step();
    recv_ack = 1'b1;
    step();
    recv_ack = 1'b0;
    chk("t3_ready_after_pop", 32'(flit_ready), 32'h1);
    step();
    flit_valid = 1'b0;
    chk("t3_drain0", 32'(recv_addr), 32'h11);
    for (int i = 2; i <= 4; i++) begin
      ack_pulse();
      chk("t3_drain", 32'(recv_addr), 32'h10 + 32'(i));
    end
    ack_pulse();
    chk("t3_drained", 32'(recv_pending), 32'h0);

    // A held ack pops exactly once.
    for (int i = 0; i < 3; i++) send(1'b1, 8'd0, 8'h21 + 8'(i));
    recv_ack = 1'b1;
    repeat (10) step();
    recv_ack = 1'b0;
    step();
    chk("t4_one_pop_addr", 32'(recv_addr), 32'h22);
    chk("t4_one_pop_pend", 32'(recv_pending), 32'h1);
    ack_pulse();
    ack_pulse();
    chk("t4_empty", 32'(recv_pending), 32'h0);

    // Ack edge coincident with a header.
    flit_valid = 1'b1;
    flit_in    = mk_flit(1'b1, 8'd0, 8'h31);
    recv_ack   = 1'b1;
    step();
    chk("t5_empty_push_addr", 32'(recv_addr), 32'h31);
    chk("t5_empty_push_pend", 32'(recv_pending), 32'h1);
    recv_ack = 1'b0;
    flit_in  = mk_flit(1'b1, 8'd0, 8'h32);
    step();
    flit_in  = mk_flit(1'b1, 8'd0, 8'h33);
    recv_ack = 1'b1;
    step();
    flit_valid = 1'b0;
    recv_ack   = 1'b0;
    step();
    chk("t5_after_swap", 32'(recv_addr), 32'h32);
    ack_pulse();
    chk("t5_last", 32'(recv_addr), 32'h33);
    ack_pulse();
    chk("t5_count_was_2", 32'(recv_pending), 32'h0);

    // Reset in the middle of a packet, then stray payload arrives in IDLE.
    send(1'b1, 8'd5, 8'h44);
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h00, 8'h00);
    do_reset();
    send(1'b0, 8'h00, 8'h77);
    chk("t6_stray_not_queued", 32'(recv_pending), 32'h0);
    send(1'b1, 8'd0, 8'h45);
    chk("t6_new_header", 32'(recv_addr), 32'h45);
    ack_pulse();

`ifdef RECV_ADDR_FRAMING_CHECK_EN
    do_reset();
    send(1'b0, 8'h00, 8'h66);
    chk("t7_ferr_set", 32'(framing_err), 32'h1);
    chk("t7_queue_unch", 32'(recv_pending), 32'h0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t7_ferr_clr", 32'(framing_err), 32'h0);
    for (int i = 0; i < 3; i++) send(1'b1, 8'd0, 8'h50 + 8'(i));
    send(1'b1, 8'd2, 8'h53);
    send(1'b1, 8'd0, 8'h55);
    chk("t7_overflow", 32'(overflow), 32'h1);
    chk("t7_ferr_hdr", 32'(framing_err), 32'h1);
    chk("t7_head_kept", 32'(recv_addr), 32'h50);
    send(1'b1, 8'd3, 8'h56);
    do_reset();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit hdr;
      flit_valid = ($urandom_range(0, 3) != 0);
      if (m_rem == 0) hdr = ($urandom_range(0, 9) != 0);
      else            hdr = ($urandom_range(0, 9) == 0);
      flit_in  = {hdr, 15'($urandom), 8'($urandom_range(0, 3)), 8'($urandom)};
      if ($urandom_range(0, 2) == 0) recv_ack = ~recv_ack;
      clr_err  = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
